// File: rtl/bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator_if
// Description : Signal bundle for bus_initiator. Carries the local request
//               port (req/we/addr/wdata/mask -> ready/done/rdata/err) and
//               the shared device-bus control lines (addr_bus, rd_bus,
//               wr_bus, data_mask_bus, fc_bus).
//               master : the initiator side (drives the bus, answers requests)
//               slave  : the requester + device side (issues requests,
//                        drives fc_bus)
//               The bidirectional data_bus is a plain inout on the module so
//               that it resolves as a normal multi-driver net.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_initiator_if;
  // Local request port
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  // Device bus control
  logic [31:0] addr_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  modport master (
    input  req, we, addr, wdata, mask, fc_bus,
    output ready, done, rdata, err, addr_bus, rd_bus, wr_bus, data_mask_bus
  );

  modport slave (
    output req, we, addr, wdata, mask, fc_bus,
    input  ready, done, rdata, err, addr_bus, rd_bus, wr_bus, data_mask_bus
  );
endinterface
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator
// Description : Single-master initiator for the shared device bus. Accepts
//               one read/write request at a time, drives the bus strobes,
//               waits for the device's function-complete (fc_bus === 1),
//               returns read data/status and enforces a release cycle (held
//               while fc_bus stays high) before the next access.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               bus      - bus_initiator_if.master (request port + bus ctrl)
//               data_bus - 32-bit bidirectional bus data; driven only while
//                          a write strobe is active, otherwise 'z
// Parameters  : TIMEOUT_CYCLES - ACCESS cycles without fc_bus before abort
//                                (1..65535, timeout build only)
// Options     : BUS_INITIATOR_TIMEOUT_EN - when defined, an access with no
//               fc_bus for TIMEOUT_CYCLES cycles completes with err = 1.
//               When undefined, ACCESS waits indefinitely and err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire             clk,
  input  wire             rst,
  bus_initiator_if.master bus,
  inout  wire [31:0]      data_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      r_state,    w_state_d;
  logic        r_we,       w_we_d;
  logic [31:0] r_wdata,    w_wdata_d;
  logic [31:0] r_addr_bus, w_addr_bus_d;
  logic [3:0]  r_mask_bus, w_mask_bus_d;
  logic        r_rd,       w_rd_d;
  logic        r_wr,       w_wr_d;
  logic [31:0] r_rdata,    w_rdata_d;
  logic        r_done,     w_done_d;
  logic        w_fc;

  // Only a solid 1 counts: an undecoded address leaves fc_bus floating.
  assign w_fc = (bus.fc_bus === 1'b1);

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] c_tmo_limit = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_tmo, w_tmo_d, w_tmo_inc;
  logic        r_err, w_err_d;
  logic        w_tmo_hit;

  // Abort on the cycle whose increment would reach the limit, so the
  // done/err pulse lands TIMEOUT_CYCLES cycles after the strobe.
  assign w_tmo_inc = r_tmo + 16'd1;
  assign w_tmo_hit = (w_tmo_inc == c_tmo_limit);
`endif

  always_comb begin
    w_state_d    = r_state;
    w_we_d       = r_we;
    w_wdata_d    = r_wdata;
    w_addr_bus_d = r_addr_bus;
    w_mask_bus_d = r_mask_bus;
    w_rd_d       = 1'b0;
    w_wr_d       = 1'b0;
    w_rdata_d    = r_rdata;
    w_done_d     = 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    w_err_d      = 1'b0;
    w_tmo_d      = r_tmo;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_we_d       = bus.we;
          w_wdata_d    = bus.wdata;
          w_addr_bus_d = bus.addr;
          w_mask_bus_d = bus.mask;
          w_rd_d       = !bus.we;
          w_wr_d       = bus.we;
          w_state_d    = ST_ACCESS;
`ifdef BUS_INITIATOR_TIMEOUT_EN
          w_tmo_d      = 16'd0;
`endif
        end
      end
      ST_ACCESS: begin
        // Strobes stay up until completion; overridden below on exit.
        w_rd_d = !r_we;
        w_wr_d = r_we;
        if (w_fc) begin
          if (!r_we) begin
            w_rdata_d = data_bus;
          end
          w_rd_d    = 1'b0;
          w_wr_d    = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = ST_RELEASE;
        end
`ifdef BUS_INITIATOR_TIMEOUT_EN
        else if (w_tmo_hit) begin
          if (!r_we) begin
            w_rdata_d = 32'd0;
          end
          w_rd_d    = 1'b0;
          w_wr_d    = 1'b0;
          w_done_d  = 1'b1;
          w_err_d   = 1'b1;
          w_state_d = ST_RELEASE;
        end else begin
          w_tmo_d = w_tmo_inc;
        end
`endif
      end
      ST_RELEASE: begin
        // Hold off until the responder drops fc, so its stale fc cannot
        // complete the next access.
        if (!w_fc) begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_addr_bus <= 32'd0;
      r_mask_bus <= 4'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      r_err      <= 1'b0;
      r_tmo      <= 16'd0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_we       <= w_we_d;
      r_wdata    <= w_wdata_d;
      r_addr_bus <= w_addr_bus_d;
      r_mask_bus <= w_mask_bus_d;
      r_rd       <= w_rd_d;
      r_wr       <= w_wr_d;
      r_rdata    <= w_rdata_d;
      r_done     <= w_done_d;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      r_err      <= w_err_d;
      r_tmo      <= w_tmo_d;
`endif
    end
  end

  assign bus.ready         = (r_state == ST_IDLE);
  assign bus.done          = r_done;
  assign bus.rdata         = r_rdata;
  assign bus.addr_bus      = r_addr_bus;
  assign bus.data_mask_bus = r_mask_bus;
  assign bus.rd_bus        = r_rd;
  assign bus.wr_bus        = r_wr;
`ifdef BUS_INITIATOR_TIMEOUT_EN
  assign bus.err           = r_err;
`else
  assign bus.err           = 1'b0;
`endif

  // The write strobe and the data drive share one register, so data is on
  // the bus exactly while a write access is in progress.
  assign data_bus = r_wr ? r_wdata : 'z;

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_initiator
// Description : Self-checking bench for bus_initiator. Contains a 16-word
//               responder at 0x1xxx_xxxx (combinational fc for reads,
//               registered fc for writes, byte-lane writes), leaves other
//               addresses undecoded (fc 'z), and compares the initiator
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_initiator;
  localparam int c_tmo    = 8;
  localparam int c_budget = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_initiator_if bif();
  wire [31:0] data_bus;

  bus_initiator #(.TIMEOUT_CYCLES(c_tmo)) dut (
    .clk(clk), .rst(rst), .bus(bif), .data_bus(data_bus)
  );

  // ---------------- responder ----------------
  logic [31:0] dev_mem [16];
  logic        dev_fc_q;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_val;
  logic        dev_mapped;
  logic [3:0]  dev_idx;

  assign dev_mapped = (bif.addr_bus[31:28] == 4'h1);
  assign dev_idx    = bif.addr_bus[5:2];
  assign data_bus   = (dev_mapped && bif.rd_bus) ? dev_mem[dev_idx] : 'z;

  always_comb begin
    if (dev_mapped) bif.fc_bus = bif.rd_bus | dev_fc_q;
    else            bif.fc_bus = 1'bz;
  end

  always @(posedge clk) begin
    dev_fc_q <= dev_mapped && bif.wr_bus;
    if (ld_en) dev_mem[ld_idx] <= ld_val;
    else if (dev_mapped && bif.wr_bus)
      for (int b = 0; b < 4; b++)
        if (bif.data_mask_bus[b]) dev_mem[dev_idx][8*b +: 8] <= data_bus[8*b +: 8];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rdata;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic bit floating(input logic [31:0] v);
    return (v === {32{1'bz}}) || (v === 32'h0);
  endfunction

  // Expected outcome of one transaction; updates the model state.
  // Latencies are in edges after the accept edge E0.
  function automatic void model_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                                    input logic [3:0] t_mask, output int e_done_k, output int e_ready_k,
                                    output int e_n_wr, output logic [31:0] e_rdata, output logic e_err);
    int idx;
    idx = int'(t_addr[5:2]);
    if (t_addr[31:28] == 4'h1) begin
      e_err = 1'b0;
      if (t_we) begin
        ref_mem[idx] = merge_lanes(ref_mem[idx], t_wdata, t_mask);
        e_done_k = 2; e_ready_k = 4; e_n_wr = 2;
      end else begin
        ref_rdata = ref_mem[idx];
        e_done_k = 1; e_ready_k = 2; e_n_wr = 0;
      end
    end else begin
      e_err = 1'b1;
      if (!t_we) ref_rdata = 32'h0;
      e_done_k = c_tmo; e_ready_k = c_tmo + 1; e_n_wr = t_we ? c_tmo : 0;
    end
    e_rdata = ref_rdata;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_word(input int idx, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx[3:0]; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Issues one request and observes it until ready returns (or budget).
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_mask, output int done_k, output int ready_k,
                         output int n_done, output int n_wr, output int n_bad,
                         output logic [31:0] got_rdata, output logic got_err);
    done_k = -1; ready_k = -1; n_done = 0; n_wr = 0; n_bad = 0; got_rdata = '0; got_err = 1'b0;
    @(negedge clk);
    bif.req = 1'b1; bif.we = t_we; bif.addr = t_addr; bif.wdata = t_wdata; bif.mask = t_mask;
    @(posedge clk);
    @(negedge clk);
    bif.req = 1'b0;
    for (int k = 0; k < c_budget && ready_k < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (bif.done === 1'b1) begin
        n_done++;
        if (done_k < 0) begin done_k = k; got_rdata = bif.rdata; got_err = bif.err; end
      end
      if (bif.wr_bus === 1'b1) begin
        n_wr++;
        if (data_bus !== t_wdata) n_bad++;
      end else if (!(bif.rd_bus === 1'b1 && dev_mapped) && !floating(data_bus)) n_bad++;
      if ((bif.rd_bus === 1'b1 || bif.wr_bus === 1'b1) &&
          (bif.addr_bus !== t_addr || bif.data_mask_bus !== t_mask)) n_bad++;
      if (bif.ready === 1'b1) ready_k = k;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bif.ready); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bif.done); end
    checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bif.err); end
    checks++; if (bif.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bif.rdata); end
    checks++; if (bif.addr_bus !== 32'h0) begin errors++; $display("FAIL reset_addr_bus: got %h expected 0", bif.addr_bus); end
    checks++; if (bif.data_mask_bus !== 4'h0) begin errors++; $display("FAIL reset_mask_bus: got %h expected 0", bif.data_mask_bus); end
    checks++; if (bif.rd_bus !== 1'b0 || bif.wr_bus !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", bif.rd_bus, bif.wr_bus); end
    checks++; if (!floating(data_bus)) begin errors++; $display("FAIL reset_data_bus: got %h expected undriven", data_bus); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bif.ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bif.ready); end
    ref_rdata = 32'h0;
    for (int i = 0; i < 16; i++) load_word(i, $urandom);
  endtask

  task automatic test_read_basic();
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd; logic er, eer;
    load_word(0, 32'hDEAD_BEEF);
    model_txn(1'b0, 32'h1000_0000, 32'h1234_5678, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h1000_0000, 32'h1234_5678, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (dk !== 1) begin errors++; $display("FAIL read_done_latency: got %0d expected 1", dk); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", er); end
    checks++; if (rk !== 2) begin errors++; $display("FAIL read_ready_latency: got %0d expected 2", rk); end
    checks++; if (nd !== 1 || nb !== 0) begin errors++; $display("FAIL read_bus_activity: got done=%0d bad=%0d expected 1/0", nd, nb); end
  endtask

  task automatic test_write_registered();
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd; logic er, eer;
    model_txn(1'b1, 32'h1000_0004, 32'h0000_0001, 4'h1, edk, erk, enw, erd, eer);
    run_txn(1'b1, 32'h1000_0004, 32'h0000_0001, 4'h1, dk, rk, nd, nw, nb, rd, er);
    checks++; if (nw !== 2) begin errors++; $display("FAIL write_strobe_len: got %0d expected 2", nw); end
    checks++; if (dk !== 2) begin errors++; $display("FAIL write_done_latency: got %0d expected 2", dk); end
    checks++; if (rk !== 4) begin errors++; $display("FAIL write_ready_latency: got %0d expected 4", rk); end
    checks++; if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL write_status: got rdata=%h err=%b expected %h/0", rd, er, erd); end
    checks++; if (dev_mem[1] !== ref_mem[1] || ref_mem[1][7:0] !== 8'h01) begin errors++; $display("FAIL write_device_reg: got %h expected %h", dev_mem[1], ref_mem[1]); end
    checks++; if (nd !== 1 || nb !== 0) begin errors++; $display("FAIL write_bus_activity: got done=%0d bad=%0d expected 1/0", nd, nb); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2, rd, erd; logic er, eer, prev_wr, prev_done, fc_low_seen;
    int rises, bad_order, n_done, consec, dk, rk, nd, nw, nb, edk, erk, enw;
    v1 = $urandom | 32'h1; v2 = $urandom | 32'h1;
    @(negedge clk);
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = 32'h1000_0014; bif.wdata = v1; bif.mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bif.addr = 32'h1000_0018; bif.wdata = v2;
    rises = 0; bad_order = 0; n_done = 0; consec = 0; fc_low_seen = 1'b0; prev_wr = 1'b0; prev_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (bif.done === 1'b1) begin n_done++; if (prev_done) consec++; end
      if (bif.wr_bus === 1'b1 && !prev_wr) begin
        rises++;
        if (rises > 1 && !fc_low_seen) bad_order++;
        if (rises > 1) bif.req = 1'b0;
      end
      if (n_done > 0 && bif.fc_bus !== 1'b1) fc_low_seen = 1'b1;
      prev_wr = (bif.wr_bus === 1'b1);
      prev_done = (bif.done === 1'b1);
    end
    bif.req = 1'b0;
    ref_mem[5] = v1; ref_mem[6] = v2;
    checks++; if (rises !== 2) begin errors++; $display("FAIL b2b_strobe_count: got %0d expected 2", rises); end
    checks++; if (bad_order !== 0) begin errors++; $display("FAIL b2b_fc_low_before_strobe: got %0d early rises expected 0", bad_order); end
    checks++; if (n_done !== 2 || consec !== 0) begin errors++; $display("FAIL b2b_done_pulses: got %0d (consecutive %0d) expected 2 (0)", n_done, consec); end
    model_txn(1'b0, 32'h1000_0018, 32'h0, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h1000_0018, 32'h0, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (rd !== v2) begin errors++; $display("FAIL b2b_second_value: got %h expected %h", rd, v2); end
    model_txn(1'b0, 32'h1000_0014, 32'h0, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h1000_0014, 32'h0, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (rd !== v1) begin errors++; $display("FAIL b2b_first_value: got %h expected %h", rd, v1); end
  endtask

  task automatic test_read_no_contention();
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd, w; logic er, eer;
    w = $urandom | 32'h8000_0001;
    model_txn(1'b1, 32'h1000_0008, w, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b1, 32'h1000_0008, w, 4'hF, dk, rk, nd, nw, nb, rd, er);
    model_txn(1'b0, 32'h1000_000C, w, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h1000_000C, w, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (nb !== 0) begin errors++; $display("FAIL read_contention: got %0d driven cycles expected 0", nb); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL read_after_write_rdata: got %h expected %h", rd, erd); end
  endtask

  task automatic test_random();
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd, a, w; logic er, eer, t_we; logic [3:0] m;
    for (int n = 0; n < 30; n++) begin
      t_we = 1'($urandom_range(0, 1));
      a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
`ifdef BUS_INITIATOR_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) a = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
`endif
      w = $urandom | 32'h1;
      m = 4'($urandom_range(1, 15));
      model_txn(t_we, a, w, m, edk, erk, enw, erd, eer);
      run_txn(t_we, a, w, m, dk, rk, nd, nw, nb, rd, er);
      checks++; if (dk !== edk || rk !== erk) begin errors++; $display("FAIL rand_latency[%0d]: got done=%0d ready=%0d expected %0d/%0d", n, dk, rk, edk, erk); end
      checks++; if (rd !== erd || er !== eer) begin errors++; $display("FAIL rand_result[%0d]: got rdata=%h err=%b expected %h/%b", n, rd, er, erd, eer); end
      checks++; if (nw !== enw || nd !== 1 || nb !== 0) begin errors++; $display("FAIL rand_bus[%0d]: got wr=%0d done=%0d bad=%0d expected %0d/1/0", n, nw, nd, nb, enw); end
    end
  endtask

  task automatic test_timeout();
`ifdef BUS_INITIATOR_TIMEOUT_EN
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd; logic er, eer;
    model_txn(1'b0, 32'h2000_0000, 32'h5555_AAAA, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h2000_0000, 32'h5555_AAAA, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (dk !== c_tmo) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", dk, c_tmo); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_status: got err=%b rdata=%h expected 1/0", er, rd); end
    checks++; if (rk !== c_tmo + 1 || nd !== 1) begin errors++; $display("FAIL timeout_release: got ready=%0d done=%0d expected %0d/1", rk, nd, c_tmo + 1); end
`else
    int nd, ne;
    @(negedge clk);
    bif.req = 1'b1; bif.we = 1'b0; bif.addr = 32'h2000_0000; bif.wdata = 32'h0; bif.mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bif.req = 1'b0;
    nd = 0; ne = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bif.done === 1'b1) nd++;
      if (bif.err !== 1'b0) ne++;
    end
    checks++; if (nd !== 0 || ne !== 0) begin errors++; $display("FAIL unmapped_wait: got done=%0d err=%0d expected 0/0", nd, ne); end
    checks++; if (bif.rd_bus !== 1'b1 || bif.ready !== 1'b0) begin errors++; $display("FAIL unmapped_still_waiting: got rd=%b ready=%b expected 1/0", bif.rd_bus, bif.ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_write();
    int dk, rk, nd, nw, nb, edk, erk, enw; logic [31:0] rd, erd, w; logic er, eer; logic [3:0] m;
    w = $urandom | 32'h1;
    m = 4'($urandom_range(1, 15));
    @(negedge clk);
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = 32'h1000_0020; bif.wdata = w; bif.mask = m;
    @(posedge clk);
    @(negedge clk);
    bif.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bif.wr_bus !== 1'b0 || !floating(data_bus)) begin errors++; $display("FAIL midrst_bus_idle: got wr=%b data=%h expected 0/undriven", bif.wr_bus, data_bus); end
    checks++; if (bif.addr_bus !== 32'h0 || bif.data_mask_bus !== 4'h0) begin errors++; $display("FAIL midrst_addr: got %h/%h expected 0/0", bif.addr_bus, bif.data_mask_bus); end
    checks++; if (bif.ready !== 1'b1 || bif.done !== 1'b0) begin errors++; $display("FAIL midrst_handshake: got ready=%b done=%b expected 1/0", bif.ready, bif.done); end
    rst = 1'b0;
    // The responder saw the strobe at the reset edge and latched the write.
    ref_mem[8] = merge_lanes(ref_mem[8], w, m);
    ref_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", bif.done); end
    model_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, edk, erk, enw, erd, eer);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, dk, rk, nd, nw, nb, rd, er);
    checks++; if (rd !== erd || dk !== edk) begin errors++; $display("FAIL midrst_recovery: got rdata=%h done=%0d expected %h/%0d", rd, dk, erd, edk); end
  endtask

  initial begin
    rst = 1'b1;
    bif.req = 1'b0; bif.we = 1'b0; bif.addr = '0; bif.wdata = '0; bif.mask = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    test_reset();
    test_read_basic();
    test_write_registered();
    test_back_to_back();
    test_read_no_contention();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
